// File: rtl/mdu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_sequencer_pkg
//  Purpose  : Shared types and constants for the multi-cycle multiply/divide
//             sequencer (FSM states, operation encoding, default width).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mdu_sequencer_pkg;

  localparam int MDU_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  typedef enum logic [1:0] {
    MDU_MUL = 2'd0,
    MDU_DIV = 2'd1,
    MDU_REM = 2'd2
  } mdu_op_t;

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : One combinational iteration of the MSB-first shift-add multiply
//             or restoring divide. The accumulator is {hi, lo}:
//               multiply : hi = running product, lo = multiplier (MSB first)
//               divide   : hi = partial remainder, lo = dividend shifting out
//                          at the top while quotient bits shift in at the bottom
//  Ports    : acc      in  2*XLEN  current accumulator
//             operand  in  XLEN    multiplicand / divisor magnitude
//             op       in  2       operation (MDU_MUL, MDU_DIV, MDU_REM)
//             acc_next out 2*XLEN  accumulator after this iteration
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iter
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  mdu_op_t           op,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] prod;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            take;

  always_comb begin
    hi      = acc[2*XLEN-1:XLEN];
    lo      = acc[XLEN-1:0];
    // Multiply: double the product and add the multiplicand for a set bit.
    addend  = lo[XLEN-1] ? operand : '0;
    prod    = {hi[XLEN-2:0], 1'b0} + addend;
    // Divide: the shifted remainder needs one extra bit before the compare.
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    take    = (shifted >= {1'b0, operand});
    if (op == MDU_MUL) begin
      acc_next = {prod, lo[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {(take ? diff[XLEN-1:0] : shifted[XLEN-1:0]), lo[XLEN-2:0], take};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_sequencer
//  Purpose  : Multi-cycle sequencer for M-extension ops. Latches operands in
//             IDLE, runs one iteration per cycle in BUSY, presents the result
//             with a one-cycle done pulse in DONE. Stalls the core while a
//             request is pending and not yet done.
//  Option   : MDU_EARLY_OUT_EN - when defined, divide-by-zero, signed
//             overflow, divide-by-1 and multiply-by-0/1 skip BUSY entirely.
//  Ports    : clk       in  1     core clock
//             reset     in  1     synchronous, active-high
//             mul_valid in  1     multiply request (held until done)
//             div_valid in  1     divide/remainder request (held until done)
//             mul_sign  in  1     signed multiply
//             div_sign  in  1     signed divide/remainder
//             mul_w     in  1     32-bit multiply variant
//             div_w     in  1     32-bit divide variant
//             rem_sel   in  1     1 = remainder, 0 = quotient
//             src_a     in  XLEN  multiplicand / dividend
//             src_b     in  XLEN  multiplier / divisor
//             stall     out 1     hold PC and writeback
//             done      out 1     result valid (one-cycle pulse)
//             result    out XLEN  product low bits, quotient or remainder
//             busy      out 1     FSM not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mul_valid,
  input  logic            div_valid,
  input  logic            mul_sign,
  input  logic            div_sign,
  input  logic            mul_w,
  input  logic            div_w,
  input  logic            rem_sel,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int HLEN  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN + 1);

  // W results keep the low half and always sign-extend it.
  function automatic logic [XLEN-1:0] w_ext(input logic [XLEN-1:0] v, input logic w);
    w_ext = w ? {{HLEN{v[HLEN-1]}}, v[HLEN-1:0]} : v;
  endfunction

  mdu_state_t          state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [2*XLEN-1:0]   acc_q,     acc_d;
  logic [XLEN-1:0]     opnd_q,    opnd_d;
  mdu_op_t             op_q,      op_d;
  logic                w_q,       w_d;
  logic                q_neg_q,   q_neg_d;
  logic                r_neg_q,   r_neg_d;
  logic                fix_q,     fix_d;
  logic [XLEN-1:0]     fix_val_q, fix_val_d;
  logic [XLEN-1:0]     result_q,  result_d;
  logic                done_q,    done_d;
  logic                busy_q,    busy_d;

  // Request decode (only consumed in IDLE)
  logic                req, req_mul, req_w, req_sign;
  mdu_op_t             req_op;
  logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag, most_neg, corner_val;
  logic                a_neg, b_neg, div_zero, div_ovf;
  logic [2*XLEN-1:0]   iter_next;
  logic [XLEN-1:0]     fin_hi, fin_lo, fin_raw;
`ifdef MDU_EARLY_OUT_EN
  logic                early_hit;
`endif

  always_comb begin
    req      = mul_valid | div_valid;
    req_mul  = mul_valid;             // illegal both-valid decode runs the multiply
    req_w    = req_mul ? mul_w : div_w;
    req_sign = req_mul ? mul_sign : div_sign;
    req_op   = req_mul ? MDU_MUL : (rem_sel ? MDU_REM : MDU_DIV);
    a_ext    = req_w ? {{HLEN{req_sign & src_a[HLEN-1]}}, src_a[HLEN-1:0]} : src_a;
    b_ext    = req_w ? {{HLEN{req_sign & src_b[HLEN-1]}}, src_b[HLEN-1:0]} : src_b;
    a_neg    = ~req_mul & req_sign & a_ext[XLEN-1];
    b_neg    = ~req_mul & req_sign & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    // Most-negative value as seen after W sign extension.
    most_neg = req_w ? {{(HLEN+1){1'b1}}, {(HLEN-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    div_ovf  = req_sign & (a_ext == most_neg) & (b_ext == '1);
    // Result for the cases that bypass or override the iteration.
    if (req_mul) begin
      corner_val = div_zero ? '0 : a_ext;
    end else if (div_zero) begin
      corner_val = rem_sel ? a_ext : '1;
    end else begin
      corner_val = rem_sel ? '0 : a_ext;
    end
`ifdef MDU_EARLY_OUT_EN
    early_hit = req_mul ? (div_zero | (b_ext == XLEN'(1)))
                        : (div_zero | div_ovf | (b_ext == XLEN'(1)));
`endif
  end

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .acc      (acc_q),
    .operand  (opnd_q),
    .op       (op_q),
    .acc_next (iter_next)
  );

  // Result as it will be once the current (final) iteration completes.
  always_comb begin
    fin_hi = iter_next[2*XLEN-1:XLEN];
    fin_lo = iter_next[XLEN-1:0];
    case (op_q)
      MDU_MUL: fin_raw = fin_hi;
      MDU_DIV: fin_raw = q_neg_q ? -fin_lo : fin_lo;
      MDU_REM: fin_raw = r_neg_q ? -fin_hi : fin_hi;
      default: fin_raw = '0;
    endcase
    if (fix_q) begin
      fin_raw = fix_val_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    w_d       = w_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    fix_d     = fix_q;
    fix_val_d = fix_val_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d      = req_op;
          w_d       = req_w;
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
          fix_d     = ~req_mul & (div_zero | div_ovf);
          fix_val_d = corner_val;
          cnt_d     = req_w ? CNT_W'(HLEN) : CNT_W'(XLEN);
          // W operands are pre-shifted so the iteration always starts at the MSB.
          if (req_mul) begin
            opnd_d = a_ext;
            acc_d  = {{XLEN{1'b0}}, (req_w ? (b_ext << HLEN) : b_ext)};
          end else begin
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, (req_w ? (a_mag << HLEN) : a_mag)};
          end
          state_d = BUSY;
`ifdef MDU_EARLY_OUT_EN
          if (early_hit) begin
            state_d  = DONE;
            result_d = w_ext(corner_val, req_w);
          end
`endif
        end
      end
      BUSY: begin
        acc_d = iter_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = w_ext(fin_raw, w_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= MDU_MUL;
      w_q       <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      fix_q     <= 1'b0;
      fix_val_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      w_q       <= w_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      fix_q     <= fix_d;
      fix_val_q <= fix_val_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign stall  = (mul_valid | div_valid) & ~done_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule
`default_nettype wire
